// File: rtl/ifetch_if.sv
// Fetch-unit bus bundle: program-memory request/ack, decoder-side head port,
// and core control (redirect, halt).
interface ifetch_if;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic       mem_ack;
   logic [7:0] mem_data;
   logic       instr_valid;
   logic [7:0] instruction;
   logic [7:0] instr_pc;
   logic       instr_ready;
   logic       jump_en;
   logic [7:0] jump_addr;
   logic       halt;
   logic       halted;

   modport master (
      output mem_req, mem_addr, instr_valid, instruction, instr_pc, halted,
      input  mem_ack, mem_data, instr_ready, jump_en, jump_addr, halt
   );

   modport slave (
      input  mem_req, mem_addr, instr_valid, instruction, instr_pc, halted,
      output mem_ack, mem_data, instr_ready, jump_en, jump_addr, halt
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction prefetcher: issues byte reads from program memory into a small
// FIFO of {byte, pc}, with redirect (flush + discard of in-flight read) and halt.
module ifetch_unit #(
   parameter int FIFO_DEPTH = 2
) (
   input logic      clk,
   input logic      rst_n,
   ifetch_if.master bus
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP, S_HALT} state_t;

   state_t                      state_q, state_d;
   logic [7:0]                  fpc_q, fpc_d;
   logic [7:0]                  raddr_q, raddr_d;
   logic [FIFO_DEPTH-1:0][7:0]  dat_q, pcs_q;
   logic [PW-1:0]               rd_q, wr_q;
   logic [PW:0]                 cnt_q;

   logic issue, ack_ok, take, push, pop;

   // A new read needs a free slot; an outstanding one already owns its slot.
   assign issue  = rst_n && (state_q == S_FETCH) && !bus.halt && !bus.jump_en
                   && (cnt_q < DEPTH_C);
   assign bus.mem_req  = issue || (rst_n && ((state_q == S_WAIT) || (state_q == S_DROP)));
   assign bus.mem_addr = ((state_q == S_WAIT) || (state_q == S_DROP)) ? raddr_q : fpc_q;

   assign ack_ok = bus.mem_ack && bus.mem_req;
   assign take   = ack_ok && (state_q != S_DROP);
   assign push   = take && !bus.jump_en;
   assign pop    = bus.instr_valid && bus.instr_ready && !bus.jump_en;

   assign bus.instr_valid = (cnt_q != '0);
   assign bus.instruction = dat_q[rd_q];
   assign bus.instr_pc    = pcs_q[rd_q];
   assign bus.halted      = (state_q == S_HALT);

   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      raddr_d = raddr_q;
      if (bus.jump_en)  fpc_d = bus.jump_addr;
      else if (take)    fpc_d = fpc_q + 8'd1;
      unique case (state_q)
         S_FETCH: begin
            if (issue && !bus.mem_ack) begin
               state_d = S_WAIT;
               raddr_d = fpc_q;
            end else if (bus.halt) begin
               state_d = S_HALT;
            end
         end
         S_WAIT: begin
            if (ack_ok)           state_d = bus.halt ? S_HALT : S_FETCH;
            else if (bus.jump_en) state_d = S_DROP;
         end
         S_DROP: begin
            if (ack_ok) state_d = bus.halt ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            if (!bus.halt) state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         fpc_q   <= 8'h00;
         raddr_q <= 8'h00;
         dat_q   <= '0;
         pcs_q   <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         raddr_q <= raddr_d;
         if (bus.jump_en) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
         end else begin
            if (push) begin
               dat_q[wr_q] <= bus.mem_data;
               pcs_q[wr_q] <= fpc_q;
               wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            case ({push, pop})
               2'b10:   cnt_q <= cnt_q + 1'b1;
               2'b01:   cnt_q <= cnt_q - 1'b1;
               default: cnt_q <= cnt_q;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed vector table, hand-written corner sequences,
// then random traffic against a queue-based reference model.
module tb_ifetch_unit;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ifetch_if bus();
   ifetch_unit #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic r, rdy, j; logic [7:0] ja; logic h, a; logic [7:0] d;
      logic chk, req; logic [7:0] addr; logic vld; logic [7:0] pc, ins; logic hlt;
   } vec_t;

   typedef struct packed { logic [7:0] d; logic [7:0] pc; } ent_t;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic rdy, input logic j, input logic [7:0] ja,
                        input logic h, input logic a, input logic [7:0] d);
      @(negedge clk);
      rst_n = r; bus.instr_ready = rdy; bus.jump_en = j; bus.jump_addr = ja;
      bus.halt = h; bus.mem_ack = a; bus.mem_data = d;
      #1;
   endtask

   vec_t tbl [18];
   ent_t q [$];
   logic       m_out, m_disc, m_halt, hh, ack_ok, exp_req;
   logic [7:0] m_fpc, m_oaddr, exp_addr;
   logic       r, rdy, j, h, a;
   logic [7:0] ja, d;

   initial begin
      rst_n = 1'b0; bus.instr_ready = 1'b0; bus.jump_en = 1'b0; bus.jump_addr = 8'h00;
      bus.halt = 1'b0; bus.mem_ack = 1'b0; bus.mem_data = 8'h00;

      //            r rdy j ja    h a d      chk req addr  vld pc    ins   hlt
      tbl[0]  = '{0,0,0,8'h00,0,0,8'h00, 0, 0,8'h00,0,8'h00,8'h00,0};
      tbl[1]  = '{0,0,0,8'h00,0,0,8'h00, 1, 0,8'h00,0,8'h00,8'h00,0};
      tbl[2]  = '{1,1,0,8'h00,0,0,8'h00, 1, 1,8'h00,0,8'h00,8'h00,0};
      tbl[3]  = '{1,1,0,8'h00,0,1,8'h11, 1, 1,8'h00,0,8'h00,8'h00,0};
      tbl[4]  = '{1,1,0,8'h00,0,0,8'h00, 1, 1,8'h01,1,8'h00,8'h11,0};
      tbl[5]  = '{1,1,0,8'h00,0,1,8'h22, 1, 1,8'h01,0,8'h00,8'h00,0};
      tbl[6]  = '{1,0,0,8'h00,0,0,8'h00, 1, 1,8'h02,1,8'h01,8'h22,0};
      tbl[7]  = '{1,0,0,8'h00,0,1,8'h33, 1, 1,8'h02,1,8'h01,8'h22,0};
      tbl[8]  = '{1,0,0,8'h00,0,0,8'h00, 1, 0,8'h03,1,8'h01,8'h22,0};
      tbl[9]  = '{1,1,0,8'h00,0,0,8'h00, 1, 0,8'h03,1,8'h01,8'h22,0};
      tbl[10] = '{1,0,0,8'h00,0,0,8'h00, 1, 1,8'h03,1,8'h02,8'h33,0};
      tbl[11] = '{1,0,1,8'h40,0,0,8'h00, 1, 1,8'h03,1,8'h02,8'h33,0};
      tbl[12] = '{1,0,0,8'h00,0,0,8'h00, 1, 1,8'h03,0,8'h00,8'h00,0};
      tbl[13] = '{1,0,0,8'h00,0,1,8'hEE, 1, 1,8'h03,0,8'h00,8'h00,0};
      tbl[14] = '{1,0,0,8'h00,0,0,8'h00, 1, 1,8'h40,0,8'h00,8'h00,0};
      tbl[15] = '{1,0,0,8'h00,0,1,8'h44, 1, 1,8'h40,0,8'h00,8'h00,0};
      tbl[16] = '{1,1,0,8'h00,0,0,8'h00, 1, 1,8'h41,1,8'h40,8'h44,0};
      tbl[17] = '{1,1,0,8'h00,0,1,8'h55, 1, 1,8'h41,0,8'h00,8'h00,0};

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].rdy, tbl[i].j, tbl[i].ja, tbl[i].h, tbl[i].a, tbl[i].d);
         if (tbl[i].chk) begin
            chk($sformatf("tbl%0d.req", i), bus.mem_req, tbl[i].req);
            chk($sformatf("tbl%0d.addr", i), bus.mem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d.valid", i), bus.instr_valid, tbl[i].vld);
            chk($sformatf("tbl%0d.halted", i), bus.halted, tbl[i].hlt);
            if (tbl[i].vld || !tbl[i].r) begin
               chk($sformatf("tbl%0d.pc", i), bus.instr_pc, tbl[i].pc);
               chk($sformatf("tbl%0d.instr", i), bus.instruction, tbl[i].ins);
            end
         end
      end

      // fetch pointer wrap 0xFE -> 0xFF -> 0x00 with same-cycle acks
      drive(0,0,0,8'h00,0,0,8'h00);
      drive(1,1,1,8'hFE,0,0,8'h00); chk("wrap.jmp_noreq", bus.mem_req, 0);
      drive(1,1,0,8'h00,0,1,8'hA0); chk("wrap.addrFE", bus.mem_addr, 8'hFE);
      chk("wrap.reqFE", bus.mem_req, 1);
      drive(1,1,0,8'h00,0,1,8'hA1); chk("wrap.addrFF", bus.mem_addr, 8'hFF);
      chk("wrap.pcFE", bus.instr_pc, 8'hFE); chk("wrap.insA0", bus.instruction, 8'hA0);
      drive(1,1,0,8'h00,0,1,8'hA2); chk("wrap.addr00", bus.mem_addr, 8'h00);
      chk("wrap.pcFF", bus.instr_pc, 8'hFF); chk("wrap.insA1", bus.instruction, 8'hA1);
      drive(1,1,0,8'h00,0,0,8'h00); chk("wrap.pc00", bus.instr_pc, 8'h00);
      chk("wrap.insA2", bus.instruction, 8'hA2); chk("wrap.addr01", bus.mem_addr, 8'h01);

      // halt with a read to 0x01 outstanding
      drive(1,0,0,8'h00,1,0,8'h00); chk("halt.req_held", bus.mem_req, 1);
      chk("halt.addr_held", bus.mem_addr, 8'h01); chk("halt.not_yet", bus.halted, 0);
      drive(1,0,0,8'h00,1,1,8'hB1); chk("halt.ack_cycle", bus.halted, 0);
      drive(1,0,0,8'h00,1,0,8'h00); chk("halt.halted", bus.halted, 1);
      chk("halt.noreq", bus.mem_req, 0); chk("halt.pushed_pc", bus.instr_pc, 8'h01);
      chk("halt.pushed_ins", bus.instruction, 8'hB1);
      drive(1,0,0,8'h00,0,0,8'h00); chk("halt.release_cycle", bus.halted, 1);
      chk("halt.release_noreq", bus.mem_req, 0);
      drive(1,0,0,8'h00,0,0,8'h00); chk("halt.resumed", bus.halted, 0);
      chk("halt.resume_req", bus.mem_req, 1); chk("halt.resume_addr", bus.mem_addr, 8'h02);

      // reset while waiting on 0x02 with a byte queued
      drive(0,0,0,8'h00,0,0,8'h00); chk("rst.req_in_reset", bus.mem_req, 0);
      drive(1,0,0,8'h00,0,0,8'h00); chk("rst.valid", bus.instr_valid, 0);
      chk("rst.addr", bus.mem_addr, 8'h00); chk("rst.req", bus.mem_req, 1);

      // random traffic vs. reference model
      hh = 1'b0; m_out = 0; m_disc = 0; m_halt = 0; m_fpc = 0; m_oaddr = 0;
      for (int i = 0; i < 800; i++) begin
         r   = (i == 0 || $urandom_range(150) == 0) ? 1'b0 : 1'b1;
         rdy = ($urandom_range(2) != 0);
         j   = ($urandom_range(11) == 0);
         ja  = 8'($urandom);
         if ($urandom_range(25) == 0) hh = !hh;
         h   = hh;
         exp_req  = r && (m_out || (!m_halt && !h && !j && q.size() < DEPTH));
         exp_addr = m_out ? m_oaddr : m_fpc;
         a   = exp_req && ($urandom_range(1) == 1);
         d   = 8'($urandom);
         drive(r, rdy, j, ja, h, a, d);
         chk("rnd.req", bus.mem_req, exp_req);
         if (i > 0) begin
            if (exp_req) chk("rnd.addr", bus.mem_addr, exp_addr);
            chk("rnd.valid", bus.instr_valid, q.size() > 0);
            chk("rnd.halted", bus.halted, m_halt);
            if (q.size() > 0) begin
               chk("rnd.pc", bus.instr_pc, q[0].pc);
               chk("rnd.instr", bus.instruction, q[0].d);
            end
         end
         if (!r) begin
            q.delete(); m_fpc = 0; m_out = 0; m_disc = 0; m_halt = 0;
         end else begin
            ack_ok = a && exp_req;
            if (j) begin
               q.delete();
               m_fpc  = ja;
               m_disc = m_out && !ack_ok;
               m_out  = m_disc;
            end else begin
               if (q.size() > 0 && rdy) void'(q.pop_front());
               if (ack_ok) begin
                  if (!m_disc) begin
                     q.push_back('{d: d, pc: exp_addr});
                     m_fpc = m_fpc + 8'd1;
                  end
                  m_out = 0; m_disc = 0;
               end else if (exp_req && !m_out) begin
                  m_out = 1; m_oaddr = m_fpc;
               end
            end
            m_halt = h && !m_out;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, number of prefetched instruction bytes held (power of two, at least 2).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
REQ-004 mem_req  output  1  program-memory read request.
REQ-005 mem_addr  output  8  program-memory byte address of the pending request.
REQ-006 mem_ack  input  1  single-cycle completion strobe for the pending request.
REQ-007 mem_data  input  8  instruction byte; valid only while mem_ack=1.
REQ-008 instr_valid  output  1  FIFO head holds an instruction byte for the decoder.
REQ-009 instruction  output  8  FIFO head byte; drives the decoder instruction input.
REQ-010 instr_pc  output  8  address the head byte was fetched from.
REQ-011 instr_ready  input  1  core consumes the head byte this cycle.
REQ-012 jump_en  input  1  redirect strobe from JMP/CALL/RET execution.
REQ-013 jump_addr  input  8  redirect target, valid while jump_en=1.
REQ-014 halt  input  1  level request to stop fetching (HLT executed).
REQ-015 halted  output  1  fetch stopped, no request outstanding.

Function
REQ-016 States: FETCH (may issue), WAIT (request outstanding), DROP (outstanding request to be discarded), HALT.
REQ-017 Internal 8-bit fetch pointer fpc; increments modulo 256 on each accepted ack (0xFF -> 0x00).
REQ-018 In FETCH, mem_req=1 with mem_addr=fpc when halt=0, jump_en=0 and FIFO occupancy < FIFO_DEPTH; enter WAIT at that edge unless mem_ack=1 in the same cycle.
REQ-019 In WAIT/DROP, mem_req and mem_addr hold stable until the mem_ack cycle; ack may arrive in the first cycle mem_req=1.
REQ-020 Ack in FETCH/WAIT: {mem_data, fpc} pushed into FIFO; instr_valid=1 from the next cycle (1-cycle latency ack -> valid).
REQ-021 instr_valid=1 iff FIFO not empty; instruction/instr_pc show head entry; pop when instr_valid&&instr_ready.
REQ-022 Push and pop in the same cycle are both performed; occupancy unchanged.
REQ-023 instr_ready while instr_valid=0 has no effect; FIFO never overflows because requests issue only with free space counting the outstanding one.
REQ-024 jump_en=1: FIFO flushed, fpc<=jump_addr at that edge; any pop or push in that cycle is discarded.
REQ-025 jump_en during WAIT without ack in the same cycle: go to DROP; the later ack is discarded and fpc is not incremented; then return to FETCH.
REQ-026 jump_en in DROP: fpc updated again, state remains DROP.
REQ-027 halt=1: no new request; an outstanding non-DROP request completes and is pushed; enter HALT once no request is outstanding.
REQ-028 HALT: halted=1, mem_req=0, FIFO contents retained and poppable; halt=0 returns to FETCH next edge.
REQ-029 jump_en and halt in the same cycle: redirect applied, then halt rules apply (next fetch from jump_addr after release).
REQ-030 FIFO read/write pointers wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.

Reset
REQ-031 While rst_n=0 at the clock edge: state FETCH, fpc=0x00, FIFO empty, any outstanding request abandoned.
REQ-032 Outputs after reset: mem_req=0 in the reset cycle, mem_addr=0x00, instr_valid=0, instruction=0x00, instr_pc=0x00, halted=0.
REQ-033 An ack arriving in the first cycle after reset release for a pre-reset request is not possible by protocol; reset mid-WAIT simply drops it.

Verification
REQ-034 Reset release, memory acks every request 1 cycle later, instr_ready=1 -> addresses 0x00,0x01,0x02... appear in order on instr_pc with matching bytes, no gaps after fill.
REQ-035 instr_ready=0, 3 bytes available -> exactly 2 pushed (depth 2), mem_req drops to 0; set instr_ready=1 -> fetching resumes at 0x02.
REQ-036 jump_en with jump_addr=0x40 while request to 0x05 is outstanding, ack 2 cycles later -> 0x05 data never on instruction; next request mem_addr=0x40; first instr_pc=0x40.
REQ-037 fpc=0xFF fetch -> next mem_addr=0x00; instr_pc sequence 0xFE,0xFF,0x00.
REQ-038 halt=1 with request outstanding -> ack pushed, halted=1 next cycle, mem_req stays 0; halt=0 -> halted=0 and fetch continues from next address.
REQ-039 rst_n=0 during WAIT with FIFO full -> next cycle instr_valid=0, fpc=0x00, first post-reset mem_addr=0x00.
